// File: rtl/pc_counter_16b_pkg.sv
// -----------------------------------------------------------------------------
// pc_counter_16b_pkg
// Shared definitions for the 6502 program-counter block and the address-bus
// driver that consumes its output.
//   - PC_ADDR_W      : address width shared with the bus driver
//   - VEC_RESET_LO/HI: default reset-vector byte addresses
//   - pc_state_e     : vector-fetch / run state encoding (2'b11 is illegal)
//   - pc_sext8       : sign extension of an 8-bit relative offset
// -----------------------------------------------------------------------------
package pc_counter_16b_pkg;

    localparam int PC_ADDR_W = 16;

    localparam logic [PC_ADDR_W-1:0] VEC_RESET_LO = 16'hFFFC;
    localparam logic [PC_ADDR_W-1:0] VEC_RESET_HI = 16'hFFFD;

    typedef enum logic [1:0] {
        PC_ST_FETCH_LO = 2'b00,
        PC_ST_FETCH_HI = 2'b01,
        PC_ST_RUN      = 2'b10
    } pc_state_e;

    function automatic logic [PC_ADDR_W-1:0] pc_sext8(input logic [7:0] off);
        return {{(PC_ADDR_W-8){off[7]}}, off};
    endfunction

endpackage

// File: rtl/pc_counter_16b_vector_fsm.sv
// -----------------------------------------------------------------------------
// pc_vector_fsm
// Reset-vector sequencer: walks FETCH_LO -> FETCH_HI -> RUN on memory acks and
// holds the captured vector low byte until the high byte arrives.
//
// state    | meaning
// ---------+------------------------------------------------------------
// FETCH_LO | requesting vector low byte, waiting for data_valid
// FETCH_HI | low byte held, requesting vector high byte
// RUN      | vector loaded, pc follows load/inc (and branch) commands
// (2'b11)  | illegal, recovers to FETCH_LO on the next edge
//
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   data_in     : latched memory byte
//   data_valid  : memory ack for data_in
//   state       : current sequencer state
//   lo_byte     : captured vector low byte
//   vec_fetch   : registered, high while a vector byte is being requested
//   busy        : registered, high in any state other than RUN
// -----------------------------------------------------------------------------
module pc_vector_fsm
    import pc_counter_16b_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output pc_state_e  state,
    output logic [7:0] lo_byte,
    output logic       vec_fetch,
    output logic       busy
);

    // vec_fetch/busy are registered alongside the state so they change on the
    // same edge that moves pc to the loaded vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= PC_ST_FETCH_LO;
            lo_byte   <= 8'h00;
            vec_fetch <= 1'b1;
            busy      <= 1'b1;
        end else begin
            case (state)
                PC_ST_FETCH_LO: begin
                    vec_fetch <= 1'b1;
                    busy      <= 1'b1;
                    if (data_valid) begin
                        lo_byte <= data_in;
                        state   <= PC_ST_FETCH_HI;
                    end
                end
                PC_ST_FETCH_HI: begin
                    if (data_valid) begin
                        state     <= PC_ST_RUN;
                        vec_fetch <= 1'b0;
                        busy      <= 1'b0;
                    end else begin
                        vec_fetch <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                PC_ST_RUN: begin
                    vec_fetch <= 1'b0;
                    busy      <= 1'b0;
                end
                default: begin
                    state     <= PC_ST_FETCH_LO;
                    lo_byte   <= 8'h00;
                    vec_fetch <= 1'b1;
                    busy      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/pc_counter_16b.sv
// -----------------------------------------------------------------------------
// pc_counter_16b
// 16-bit program counter for the 6502 datapath. After reset it fetches the
// reset vector from VEC_LO/VEC_HI through a byte handshake, then counts.
// In RUN the command priority per edge is load > (branch >) inc > hold.
//
// Optional feature macro: PC_COUNTER_BRANCH_EN
//   adds branch / branch_offset ports; pc += sign_extend(branch_offset).
//
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   data_in        : latched memory byte during vector fetch
//   data_valid     : memory ack, data_in valid this cycle
//   inc            : pc <= pc + 1 (RUN only)
//   load           : pc <= load_value (RUN only)
//   load_value     : parallel load value
//   branch         : pc <= pc + sext(branch_offset) (RUN only, macro only)
//   branch_offset  : two's-complement relative offset (macro only)
//   pc             : registered fetch address
//   vec_fetch      : high while the vector sequence requests a byte
//   busy           : high in any state other than RUN
// -----------------------------------------------------------------------------
module pc_counter_16b
    import pc_counter_16b_pkg::*;
#(
    parameter logic [PC_ADDR_W-1:0] VEC_LO = VEC_RESET_LO,
    parameter logic [PC_ADDR_W-1:0] VEC_HI = VEC_RESET_HI
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           data_in,
    input  logic                 data_valid,
    input  logic                 inc,
    input  logic                 load,
    input  logic [PC_ADDR_W-1:0] load_value,
`ifdef PC_COUNTER_BRANCH_EN
    input  logic                 branch,
    input  logic [7:0]           branch_offset,
`endif
    output logic [PC_ADDR_W-1:0] pc,
    output logic                 vec_fetch,
    output logic                 busy
);

    pc_state_e  state;
    logic [7:0] lo_byte;

    pc_vector_fsm u_vector_fsm (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .state      (state),
        .lo_byte    (lo_byte),
        .vec_fetch  (vec_fetch),
        .busy       (busy)
    );

    // pc steps in lockstep with the sequencer: it presents the byte address
    // being requested and takes the assembled vector on the final ack.
    // Commands are only decoded in RUN, so nothing is queued while busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= VEC_LO;
        end else begin
            case (state)
                PC_ST_FETCH_LO: begin
                    pc <= data_valid ? VEC_HI : VEC_LO;
                end
                PC_ST_FETCH_HI: begin
                    if (data_valid)
                        pc <= {data_in, lo_byte};
                    else
                        pc <= VEC_HI;
                end
                PC_ST_RUN: begin
                    if (load)
                        pc <= load_value;
`ifdef PC_COUNTER_BRANCH_EN
                    else if (branch)
                        pc <= pc + pc_sext8(branch_offset);
`endif
                    else if (inc)
                        pc <= pc + 16'd1;
                end
                default: begin
                    pc <= VEC_LO;
                end
            endcase
        end
    end

endmodule
